// File: rtl/fpnew_hub_pkg.sv
// Shared types and helpers for the HUB square-root unit.
package fpnew_hub_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} hub_sqrt_state_e;

  function automatic int unsigned sqrt_iterations(input fpnew_pkg::fp_format_e fmt,
                                                  input logic radix4);
    int unsigned bits;
    bits = fpnew_pkg::man_bits(fmt) + 1;
    return radix4 ? (bits + 1) / 2 : bits;
  endfunction

  // Sign clear, exponent all ones, mantissa MSB set; right-aligned in 64 bits.
  function automatic logic [63:0] hub_canonical_nan(input fpnew_pkg::fp_format_e fmt);
    logic [63:0] nan;
    int unsigned w;
    int unsigned m;
    w   = fpnew_pkg::fp_width(fmt);
    m   = fpnew_pkg::man_bits(fmt);
    nan = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((i + 1 >= m) && (i + 1 < w)) nan[i] = 1'b1;
    end
    return nan;
  endfunction

endpackage

// File: rtl/fpnew_pkg.sv
// Minimal FPnew type/format package: formats, operations and status flags used by the HUB slice.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned exp_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned man_bits(input fp_format_e fmt);
    case (fmt)
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 23;
    endcase
  endfunction

endpackage

// File: rtl/fpnew_hub_sqrt_step.sv
// One combinational restoring square-root step: shifts in two radicand bits, tries (root<<2)|1.
module fpnew_hub_sqrt_step #(
  parameter int unsigned RemWidth  = 27,
  parameter int unsigned RootWidth = 24
) (
  input  logic [RemWidth-1:0]  rem,
  input  logic [RootWidth-1:0] root,
  input  logic [1:0]           rad_bits,
  output logic [RemWidth-1:0]  rem_next,
  output logic                 root_bit
);

  logic [RemWidth-1:0] shifted;
  logic [RemWidth-1:0] trial;
  logic                unused_rem_top;

  // The remainder never exceeds 2*root, so its top two bits are always zero here.
  assign shifted        = {rem[RemWidth-3:0], rad_bits};
  assign trial          = {{(RemWidth-RootWidth-2){1'b0}}, root, 2'b01};
  assign root_bit       = (shifted >= trial);
  assign rem_next       = root_bit ? shifted - trial : shifted;
  assign unused_rem_top = ^rem[RemWidth-1:RemWidth-2];

endmodule

// File: rtl/fpnew_hub_sqrt_wrapper.sv
// Iterative HUB square root, one root bit per cycle (two with FPNEW_HUB_SQRT_RADIX4_EN defined).
module fpnew_hub_sqrt_wrapper
  import fpnew_hub_pkg::*;
#(
  parameter fpnew_pkg::fp_format_e FpFormat    = fpnew_pkg::fp_format_e'(0),
  parameter int unsigned           NumOperands = 2,
  localparam int unsigned          FP_WIDTH    = fpnew_pkg::fp_width(FpFormat)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumOperands*FP_WIDTH-1:0] operands_i,
  input  fpnew_pkg::operation_e           op_i,
  input  logic                            op_mod_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic                            flush_i,
  output logic [FP_WIDTH-1:0]             result_o,
  output fpnew_pkg::status_t              status_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o
);

  localparam int unsigned EXP_BITS = fpnew_pkg::exp_bits(FpFormat);
  localparam int unsigned MAN_BITS = fpnew_pkg::man_bits(FpFormat);
  localparam int unsigned ITER     = MAN_BITS + 1;
  localparam int unsigned REM_W    = MAN_BITS + 4;
  localparam int unsigned RAD_W    = 2 * ITER;
`ifdef FPNEW_HUB_SQRT_RADIX4_EN
  localparam logic        RADIX4   = 1'b1;
`else
  localparam logic        RADIX4   = 1'b0;
`endif
  localparam int unsigned ITER_CYC = sqrt_iterations(FpFormat, RADIX4);
  localparam int unsigned CNT_W    = $clog2(ITER_CYC + 1);
  localparam logic [CNT_W-1:0]            LAST_CNT = CNT_W'(ITER_CYC - 1);
  localparam logic signed [EXP_BITS+1:0]  BIAS     = (EXP_BITS+2)'((1 << (EXP_BITS-1)) - 1);
  localparam logic [FP_WIDTH-1:0]         QNAN     = FP_WIDTH'(hub_canonical_nan(FpFormat));

  hub_sqrt_state_e state_q, state_d;

  logic [FP_WIDTH-1:0]   operand;
  logic                  sign;
  logic [EXP_BITS-1:0]   exp_field;
  logic [MAN_BITS-1:0]   man_field;
  logic                  is_zero, exp_max, is_nan, is_snan, is_special;
  logic                  accept, last_iter;
  logic [FP_WIDTH-1:0]   special_res;
  fpnew_pkg::status_t    special_status;
  logic signed [EXP_BITS+1:0] exp_unb, exp_half;
  logic [MAN_BITS+1:0]   sig;
  logic [RAD_W-1:0]      rad_init, rad_q, rad_n;
  logic [REM_W-1:0]      rem_q, rem_a, rem_n;
  logic [ITER-1:0]       root_q, root_a, root_n;
  logic                  bit_a;
  logic [EXP_BITS-1:0]   res_exp_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  unused_bits;

  assign operand                       = operands_i[FP_WIDTH-1:0];
  assign {sign, exp_field, man_field}  = operand;
  assign is_zero    = (exp_field == '0);
  assign exp_max    = &exp_field;
  assign is_nan     = exp_max & (man_field != '0);
  assign is_snan    = is_nan & ~man_field[MAN_BITS-1];
  assign is_special = is_zero | exp_max | sign;

  assign in_ready_o  = (state_q == IDLE) && (op_i == fpnew_pkg::SQRT);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign last_iter   = (cnt_q == LAST_CNT);

  // NaN is checked before sign so a negative NaN keeps its quiet/signalling flag behaviour.
  always_comb begin
    special_res    = QNAN;
    special_status = '0;
    if (is_nan) begin
      special_status.NV = is_snan;
    end else if (is_zero) begin
      special_res = {sign, {(FP_WIDTH-1){1'b0}}};
    end else if (sign) begin
      special_status.NV = 1'b1;
    end else begin
      special_res = operand;
    end
  end

  // Odd unbiased exponents fold one factor of two into the radicand before halving.
  assign exp_unb  = $signed({2'b00, exp_field}) - BIAS;
  assign exp_half = (exp_unb >>> 1) + BIAS;
  assign sig      = {1'b1, man_field, 1'b1};
  assign rad_init = exp_unb[0] ? {sig, 1'b0, {(MAN_BITS-1){1'b0}}}
                               : {1'b0, sig, {(MAN_BITS-1){1'b0}}};

  fpnew_hub_sqrt_step #(.RemWidth(REM_W), .RootWidth(ITER)) i_step_a (
    .rem      (rem_q),
    .root     (root_q),
    .rad_bits (rad_q[RAD_W-1 -: 2]),
    .rem_next (rem_a),
    .root_bit (bit_a)
  );
  assign root_a = {root_q[ITER-2:0], bit_a};

`ifdef FPNEW_HUB_SQRT_RADIX4_EN
  localparam logic ODD_TAIL = ((ITER % 2) == 1);
  logic [REM_W-1:0] rem_b;
  logic [ITER-1:0]  root_b;
  logic             bit_b;

  fpnew_hub_sqrt_step #(.RemWidth(REM_W), .RootWidth(ITER)) i_step_b (
    .rem      (rem_a),
    .root     (root_a),
    .rad_bits (rad_q[RAD_W-3 -: 2]),
    .rem_next (rem_b),
    .root_bit (bit_b)
  );
  assign root_b = {root_a[ITER-2:0], bit_b};

  // With an odd bit count the final cycle only has one root bit left to produce.
  always_comb begin
    rem_n  = rem_a;
    root_n = root_a;
    rad_n  = rad_q << 2;
    if (!(ODD_TAIL && last_iter)) begin
      rem_n  = rem_b;
      root_n = root_b;
      rad_n  = rad_q << 4;
    end
  end
`else
  always_comb begin
    rem_n  = rem_a;
    root_n = root_a;
    rad_n  = rad_q << 2;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = is_special ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // The leading root bit is always 1, so the low MAN_BITS root bits are the truncated mantissa.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      res_exp_q <= '0;
      result_o  <= '0;
      status_o  <= '0;
    end else if (!flush_i) begin
      if (accept) begin
        if (is_special) begin
          result_o <= special_res;
          status_o <= special_status;
        end else begin
          rad_q     <= rad_init;
          rem_q     <= '0;
          root_q    <= '0;
          cnt_q     <= '0;
          res_exp_q <= exp_half[EXP_BITS-1:0];
        end
      end else if (state_q == CALC) begin
        rad_q  <= rad_n;
        rem_q  <= rem_n;
        root_q <= root_n;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (last_iter) begin
          result_o <= {1'b0, res_exp_q, root_n[MAN_BITS-1:0]};
          status_o <= fpnew_pkg::status_t'(5'b00001);
        end
      end
    end
  end

  assign unused_bits = ^{op_mod_i, operands_i, exp_half[EXP_BITS+1:EXP_BITS], root_n[ITER-1]};

endmodule

// File: tb/tb_fpnew_hub_sqrt_wrapper.sv
// Scoreboard bench for fpnew_hub_sqrt_wrapper (FP32); honours FPNEW_HUB_SQRT_RADIX4_EN for latency.
module tb_fpnew_hub_sqrt_wrapper;

`ifdef FPNEW_HUB_SQRT_RADIX4_EN
  localparam int CALC_LAT = 13;
`else
  localparam int CALC_LAT = 25;
`endif

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [63:0]           operands_i = '0;
  fpnew_pkg::operation_e op_i = fpnew_pkg::SQRT;
  logic                  op_mod_i = 1'b0;
  logic                  in_valid_i = 1'b0;
  logic                  in_ready_o;
  logic                  flush_i = 1'b0;
  logic [31:0]           result_o;
  fpnew_pkg::status_t    status_o;
  logic                  out_valid_o;
  logic                  out_ready_i = 1'b0;
  logic                  busy_o;
  logic [4:0]            st;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  st;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   check_count = 0;
  int   pass_count  = 0;

  assign st = status_o;

  fpnew_hub_sqrt_wrapper #(.FpFormat(fpnew_pkg::FP32), .NumOperands(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .operands_i  (operands_i),
    .op_i        (op_i),
    .op_mod_i    (op_mod_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .status_o    (status_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Hands one operand over and records what the unit must produce for it.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] er,
                               input logic [4:0] es, input int lat);
    exp_t e;
    e.res = er; e.st = es; e.lat = lat;
    sb.push_back(e);
    @(negedge clk_i);
    operands_i = {32'h0, a};
    op_i       = fpnew_pkg::SQRT;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk_i);
      #1 lat++;
    end
  endtask

  task automatic releaseOutput();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_count++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b100)
      $display("[TB] FAIL reset_ctrl: got %b expected 100", {in_ready_o, out_valid_o, busy_o});
    else pass_count++;
    check_count++;
    if ({result_o, st} !== 37'h0)
      $display("[TB] FAIL reset_data: got %h/%b expected 0/0", result_o, st);
    else pass_count++;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_sqrt2();
    int lat;
    exp_t e;
    applyStimulus(32'h40000000, 32'h3FB504F3, 5'b00001, CALC_LAT);
    waitValid(lat);
    e = sb.pop_front();
    check_count++;
    if (lat !== e.lat) $display("[TB] FAIL sqrt2_latency: got %0d expected %0d", lat, e.lat);
    else pass_count++;
    check_count++;
    if (result_o !== e.res) $display("[TB] FAIL sqrt2_result: got %h expected %h", result_o, e.res);
    else pass_count++;
    check_count++;
    if (st !== e.st) $display("[TB] FAIL sqrt2_status: got %b expected %b", st, e.st);
    else pass_count++;
    releaseOutput();
    check_count++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b100)
      $display("[TB] FAIL sqrt2_idle: got %b expected 100", {in_ready_o, out_valid_o, busy_o});
    else pass_count++;
  endtask

  task automatic test_busy_ready();
    int   lat;
    int   viol;
    exp_t e;
    applyStimulus(32'h40800000, 32'h40000000, 5'b00001, CALC_LAT);
    lat  = 1;
    viol = 0;
    while (!out_valid_o && lat < 200) begin
      if (!busy_o || in_ready_o) viol++;
      @(posedge clk_i);
      #1 lat++;
    end
    e = sb.pop_front();
    check_count++;
    if (viol !== 0) $display("[TB] FAIL busy_ready: got %0d bad cycles expected 0", viol);
    else pass_count++;
    check_count++;
    if ({result_o, st} !== {e.res, e.st})
      $display("[TB] FAIL sqrt4_result: got %h/%b expected %h/%b", result_o, st, e.res, e.st);
    else pass_count++;
    releaseOutput();
  endtask

  task automatic test_specials_and_values();
    logic [31:0] ops [10] = '{32'hBF800000, 32'h80000000, 32'h7F800000, 32'h7F800001,
                              32'h7FC00001, 32'hFF800000, 32'h3F800000, 32'h41100000,
                              32'h3E800000, 32'h3F000000};
    logic [31:0] res [10] = '{32'h7FC00000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
                              32'h7FC00000, 32'h7FC00000, 32'h3F800000, 32'h40400000,
                              32'h3F000000, 32'h3F3504F3};
    logic [4:0]  sts [10] = '{5'b10000, 5'b00000, 5'b00000, 5'b10000, 5'b00000,
                              5'b10000, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    int   lat;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(ops[i], res[i], sts[i], (i < 6) ? 1 : CALC_LAT);
      waitValid(lat);
      e = sb.pop_front();
      check_count++;
      if ({result_o, st} !== {e.res, e.st} || lat !== e.lat)
        $display("[TB] FAIL value_%h: got %h/%b lat %0d expected %h/%b lat %0d",
                 ops[i], result_o, st, lat, e.res, e.st, e.lat);
      else pass_count++;
      releaseOutput();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    int   bad;
    exp_t e;
    applyStimulus(32'h41100000, 32'h40400000, 5'b00001, CALC_LAT);
    waitValid(lat);
    e   = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      if (result_o !== e.res || st !== e.st || !out_valid_o || in_ready_o) bad++;
    end
    check_count++;
    if (bad !== 0) $display("[TB] FAIL backpressure_hold: got %0d bad cycles expected 0", bad);
    else pass_count++;
    releaseOutput();
    check_count++;
    if ({in_ready_o, out_valid_o} !== 2'b10)
      $display("[TB] FAIL backpressure_release: got %b expected 10", {in_ready_o, out_valid_o});
    else pass_count++;
  endtask

  task automatic test_non_sqrt_op();
    int bad = 0;
    @(negedge clk_i);
    operands_i = {32'h0, 32'h40800000};
    op_i       = fpnew_pkg::DIV;
    in_valid_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i);
      #1;
      if (in_ready_o || busy_o || out_valid_o) bad++;
    end
    in_valid_i = 1'b0;
    op_i       = fpnew_pkg::SQRT;
    check_count++;
    if (bad !== 0) $display("[TB] FAIL non_sqrt_reject: got %0d bad cycles expected 0", bad);
    else pass_count++;
  endtask

  task automatic test_flush();
    int   lat;
    int   seen;
    exp_t e;
    applyStimulus(32'h40000000, 32'h3FB504F3, 5'b00001, CALC_LAT);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    e = sb.pop_front();
    check_count++;
    if ({in_ready_o, busy_o, out_valid_o} !== 3'b100)
      $display("[TB] FAIL flush_idle: got %b expected 100", {in_ready_o, busy_o, out_valid_o});
    else pass_count++;
    seen = 0;
    repeat (30) begin
      @(posedge clk_i);
      #1 if (out_valid_o) seen++;
    end
    check_count++;
    if (seen !== 0) $display("[TB] FAIL flush_no_valid: got %0d expected 0", seen);
    else pass_count++;
    applyStimulus(32'h40800000, 32'h40000000, 5'b00001, CALC_LAT);
    waitValid(lat);
    e = sb.pop_front();
    check_count++;
    if ({result_o, st} !== {e.res, e.st} || lat !== e.lat)
      $display("[TB] FAIL after_flush: got %h/%b lat %0d expected %h/%b lat %0d",
               result_o, st, lat, e.res, e.st, e.lat);
    else pass_count++;
    releaseOutput();
  endtask

  task automatic test_async_reset();
    exp_t e;
    applyStimulus(32'h40000000, 32'h3FB504F3, 5'b00001, CALC_LAT);
    repeat (5) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    e = sb.pop_front();
    check_count++;
    if ({in_ready_o, out_valid_o, busy_o} !== 3'b100 || result_o !== 32'h0 || st !== 5'b0)
      $display("[TB] FAIL async_reset: got %b %h %b expected 100 00000000 00000",
               {in_ready_o, out_valid_o, busy_o}, result_o, st);
    else pass_count++;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sqrt2();
    test_busy_ready();
    test_specials_and_values();
    test_backpressure();
    test_non_sqrt_op();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fpnew_hub_sqrt_wrapper.md
Name: fpnew_hub_sqrt_wrapper

Overview:
Iterative HUB-format square-root unit. It is the responder for the SQRT operation issued by the DIVSQRT lane of a format slice, on the same valid/ready/flush operation handshake the lane uses for DIV. Each operation computes one scalar square root, one root bit per cycle, with HUB round-to-nearest applied by truncation. Results are held until the lane accepts them.

Parameters:
FpFormat, fpnew_pkg::fp_format_e'(0), operand/result format; sets FP_WIDTH, EXP_BITS and MAN_BITS via fpnew_pkg.
NumOperands, 2, number of operand slots; only operands_i[0] is used.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
operands_i  input  NumOperands*FP_WIDTH  packed operands; slot 0 is the radicand
op_i  input  fpnew_pkg::operation_e  operation; only SQRT is accepted
op_mod_i  input  1  ignored
in_valid_i  input  1  request valid
in_ready_o  output  1  request ready
flush_i  input  1  synchronous abort
result_o  output  FP_WIDTH  HUB result
status_o  output  fpnew_pkg::status_t  {NV,DZ,OF,UF,NX}
out_valid_o  output  1  result valid
out_ready_i  input  1  result ready
busy_o  output  1  operation in flight

Behaviour:
- Interface fixed: one clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: state IDLE; in_ready_o=1 (if op_i==SQRT); out_valid_o=0; busy_o=0; result_o=0; status_o=0.
- Operand encoding: exp==0 is zero; there are no subnormals. exp==all-ones with man==0 is infinity; with man!=0 it is NaN. A NaN with man MSB clear is a signalling NaN. Finite significand is {1,man,1}; the trailing 1 is the implicit ILSB.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o = (op_i==SQRT).
  - A handshake (in_valid_i & in_ready_o) classifies the operand.
  - Special operand goes to DONE next cycle, so out_valid_o rises 1 cycle after acceptance.
  - Finite nonzero operand goes to CALC.
- Special results:
  - NaN gives 0x7FC00000-style canonical qNaN; NV=1 only for sNaN.
  - Negative nonzero (including -inf) gives qNaN with NV=1.
  - ±0 gives ±0 with no flags.
  - +inf gives +inf with no flags.
- CALC:
  - Unbiased exponent u = exp - bias. If u is odd, the significand is shifted left by 1.
  - Result exp = floor(u/2) + bias, using arithmetic shift.
  - Restoring radix-2 recurrence computes ITER = MAN_BITS+1 root bits, one per cycle, with an iteration counter from 0 to ITER-1.
  - Remainder width is MAN_BITS+4 bits.
  - The top root bit is always 1 and is dropped. The remaining MAN_BITS bits form result man (truncation = HUB nearest).
  - After the last iteration, go to DONE. out_valid_o rises ITER+1 cycles after acceptance.
  - Status for every finite result: NX=1; NV=DZ=OF=UF=0. Overflow and underflow are impossible.
- DONE:
  - out_valid_o=1; result_o and status_o are stable.
  - On out_ready_i, go to IDLE. There is no same-cycle re-acceptance; in_ready_o=0 in DONE.
- busy_o=1 in CALC and DONE.
- A non-SQRT op_i with in_valid_i is never accepted, because in_ready_o=0.
- flush_i in any state returns to IDLE next cycle and drops out_valid_o. Flush has priority over an accept or an output handshake in the same cycle.
- Reset mid-operation forces the reset values immediately.

Optional Feature:
FPNEW_HUB_SQRT_RADIX4_EN:
- Defined: two recurrence steps are chained per cycle; ITER_CYC = ceil((MAN_BITS+1)/2). For an odd bit count, the final cycle applies one step only. Latency is ITER_CYC+1. Results are bit-identical to radix-2.
- Undefined: one step per cycle, as in Behaviour.

Decomposition:
- Package fpnew_hub_pkg holds:
  - hub_sqrt_state_e {IDLE,CALC,DONE}
  - function sqrt_iterations(fp_format_e, logic radix4)
  - function hub_canonical_nan(fp_format_e)
- Sub-module fpnew_hub_sqrt_step is one combinational restoring step: (remainder, partial root, next two radicand bits) in, (new remainder, root bit) out. It is instantiated once, or twice under the macro.

Test Plan:
- FP32, sqrt 0x40000000 (2.0, odd exponent) -> result 0x3FB504F3, NX=1; out_valid_o rises 25 cycles after acceptance (13 with radix-4).
- FP32, sqrt 0x40800000 (4.0) -> 0x40000000, NX=1; in_ready_o=0 while busy_o=1.
- FP32, sqrt 0xBF800000 -> 0x7FC00000, NV=1; sqrt 0x80000000 -> 0x80000000, flags 0; sqrt 0x7F800000 -> 0x7F800000, flags 0; each with out_valid_o 1 cycle after acceptance.
- FP32, sqrt 0x7F800001 (sNaN) -> 0x7FC00000, NV=1; sqrt 0x7FC00001 (qNaN) -> 0x7FC00000, flags 0.
- Back-pressure: hold out_ready_i=0 for 5 cycles in DONE -> result_o/status_o stable, out_valid_o=1, in_ready_o=0. Release -> IDLE next cycle.
- flush_i at CALC iteration 10 -> out_valid_o never asserted, in_ready_o=1 next cycle; a following sqrt 0x40800000 yields 0x40000000. Also assert rst_ni low mid-CALC -> all outputs return to reset values asynchronously.
